// File: rtl/mips_alu_pkg.sv
// Shared encodings for the MIPS ALU: control codes, ALUOp selector, funct and opcode values.
// Used by the control unit, the ID/EX issue stage and the ALU.
package mips_alu_pkg;

   typedef enum logic [3:0] {
      CTL_AND = 4'd0,
      CTL_OR  = 4'd1,
      CTL_ADD = 4'd2,
      CTL_SUB = 4'd6,
      CTL_SLT = 4'd7,
      CTL_NOR = 4'd12,
      CTL_NOP = 4'd15
   } alu_ctl_e;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_RTYPE = 2'b10,
      ALUOP_ITYPE = 2'b11
   } aluop_e;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_NOR = 6'h27;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_SLTI = 6'h0A;
   localparam logic [5:0] OP_ANDI = 6'h0C;
   localparam logic [5:0] OP_ORI  = 6'h0D;

endpackage

// File: rtl/alu_ctl_decode.sv
// Combinational translation of ALUOp/funct/opcode into the 4-bit ALU control code.
// Unsupported funct/opcode values yield the NOP code and raise illegal.
module alu_ctl_decode
   import mips_alu_pkg::*;
(
   input  logic [1:0] aluop,
   input  logic [5:0] funct,
   input  logic [5:0] op,
   output logic [3:0] ctl,
   output logic       illegal
);

   // ALU control code lookup
   always_comb begin
      ctl     = CTL_NOP;
      illegal = 1'b0;
      case (aluop_e'(aluop))
         ALUOP_ADD: ctl = CTL_ADD;
         ALUOP_SUB: ctl = CTL_SUB;
         ALUOP_RTYPE: begin
            case (funct)
               FN_ADD:  ctl = CTL_ADD;
               FN_SUB:  ctl = CTL_SUB;
               FN_AND:  ctl = CTL_AND;
               FN_OR:   ctl = CTL_OR;
               FN_NOR:  ctl = CTL_NOR;
               FN_SLT:  ctl = CTL_SLT;
               default: begin
                  ctl     = CTL_NOP;
                  illegal = 1'b1;
               end
            endcase
         end
         ALUOP_ITYPE: begin
            case (op)
               OP_ADDI: ctl = CTL_ADD;
               OP_ANDI: ctl = CTL_AND;
               OP_ORI:  ctl = CTL_OR;
               OP_SLTI: ctl = CTL_SLT;
               default: begin
                  ctl     = CTL_NOP;
                  illegal = 1'b1;
               end
            endcase
         end
         default: begin
            ctl     = CTL_NOP;
            illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/id_ex_issue.sv
// ID/EX pipeline register feeding the ALU: operand capture, ALU control decode,
// EX/MEM and MEM/WB forwarding, and load-use hazard bubble insertion.
module id_ex_issue
   import mips_alu_pkg::*;
#(
   parameter int LEN     = 32,
   parameter int REGBITS = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [REGBITS-1:0] in_rs,
   input  logic [REGBITS-1:0] in_rt,
   input  logic [REGBITS-1:0] in_rd_dst,
   input  logic [LEN-1:0]     in_rs_val,
   input  logic [LEN-1:0]     in_rt_val,
   input  logic [LEN-1:0]     in_imm,
   input  logic [1:0]         in_aluop,
   input  logic [5:0]         in_funct,
   input  logic [5:0]         in_op,
   input  logic               in_alusrc,
   input  logic               in_memrd,
   input  logic               in_memwr,
   input  logic               in_regwr,
   input  logic               stall,
   input  logic               flush,
   input  logic               exmem_regwr,
   input  logic               memwb_regwr,
   input  logic [REGBITS-1:0] exmem_rd,
   input  logic [REGBITS-1:0] memwb_rd,
   input  logic [LEN-1:0]     exmem_val,
   input  logic [LEN-1:0]     memwb_val,
   output logic [LEN-1:0]     A,
   output logic [LEN-1:0]     B,
   output logic [3:0]         ALUctl,
   output logic [LEN-1:0]     st_data,
   output logic [REGBITS-1:0] ex_rd,
   output logic               ex_valid,
   output logic               ex_memrd,
   output logic               ex_memwr,
   output logic               ex_regwr,
   output logic               illegal
);

   logic [REGBITS-1:0] ex_rs;
   logic [REGBITS-1:0] ex_rt;
   logic [LEN-1:0]     ex_rs_val;
   logic [LEN-1:0]     ex_rt_val;
   logic [LEN-1:0]     ex_imm;
   logic               ex_alusrc;
   logic [3:0]         dec_ctl;
   logic               dec_illegal;
   logic               hz;
   logic [LEN-1:0]     fwd_rs;
   logic [LEN-1:0]     fwd_rt;

   alu_ctl_decode u_dec (
      .aluop   (in_aluop),
      .funct   (in_funct),
      .op      (in_op),
      .ctl     (dec_ctl),
      .illegal (dec_illegal)
   );

   // A load in EX whose destination is read by the ID instruction cannot be forwarded in time.
   assign hz       = in_valid & ex_valid & ex_memrd & (ex_rd != {REGBITS{1'b0}})
                     & ((ex_rd == in_rs) | (ex_rd == in_rt));
   assign in_ready = ~stall & ~hz;

   // ID/EX register update: reset > flush > stall > hazard bubble > load
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_valid  <= 1'b0;
         ex_memrd  <= 1'b0;
         ex_memwr  <= 1'b0;
         ex_regwr  <= 1'b0;
         illegal   <= 1'b0;
         ALUctl    <= CTL_NOP;
         ex_rd     <= {REGBITS{1'b0}};
         ex_rs     <= {REGBITS{1'b0}};
         ex_rt     <= {REGBITS{1'b0}};
         ex_rs_val <= {LEN{1'b0}};
         ex_rt_val <= {LEN{1'b0}};
         ex_imm    <= {LEN{1'b0}};
         ex_alusrc <= 1'b0;
      end else if (flush || (!stall && hz)) begin
         ex_valid <= 1'b0;
         ex_memrd <= 1'b0;
         ex_memwr <= 1'b0;
         ex_regwr <= 1'b0;
         illegal  <= 1'b0;
      end else if (stall) begin
         ex_valid <= ex_valid;
      end else begin
         ex_valid  <= in_valid;
         ex_memrd  <= in_valid & in_memrd;
         ex_memwr  <= in_valid & in_memwr;
         ex_regwr  <= in_valid & in_regwr;
         illegal   <= in_valid & dec_illegal;
         ALUctl    <= dec_ctl;
         ex_rd     <= in_rd_dst;
         ex_rs     <= in_rs;
         ex_rt     <= in_rt;
         ex_rs_val <= in_rs_val;
         ex_rt_val <= in_rt_val;
         ex_imm    <= in_imm;
         ex_alusrc <= in_alusrc;
      end
   end

   // rs forwarding; $zero is never forwarded and EX/MEM wins over MEM/WB
   always_comb begin
      fwd_rs = ex_rs_val;
      if (ex_rs == {REGBITS{1'b0}}) begin
         fwd_rs = ex_rs_val;
      end else if (exmem_regwr && (exmem_rd == ex_rs)) begin
         fwd_rs = exmem_val;
      end else if (memwb_regwr && (memwb_rd == ex_rs)) begin
         fwd_rs = memwb_val;
      end else begin
         fwd_rs = ex_rs_val;
      end
   end

   // rt forwarding, same priority as rs
   always_comb begin
      fwd_rt = ex_rt_val;
      if (ex_rt == {REGBITS{1'b0}}) begin
         fwd_rt = ex_rt_val;
      end else if (exmem_regwr && (exmem_rd == ex_rt)) begin
         fwd_rt = exmem_val;
      end else if (memwb_regwr && (memwb_rd == ex_rt)) begin
         fwd_rt = memwb_val;
      end else begin
         fwd_rt = ex_rt_val;
      end
   end

   assign A       = fwd_rs;
   assign B       = ex_alusrc ? ex_imm : fwd_rt;
   assign st_data = fwd_rt;

endmodule

// File: tb/tb_id_ex_issue.sv
// Directed plus randomized bench for id_ex_issue, checked against a behavioural
// model of the EX-stage contents kept as a plain struct.
module tb_id_ex_issue;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, in_ready;
   logic [4:0]  in_rs, in_rt, in_rd_dst, exmem_rd, memwb_rd, ex_rd;
   logic [31:0] in_rs_val, in_rt_val, in_imm, exmem_val, memwb_val, A, B, st_data;
   logic [1:0]  in_aluop;
   logic [5:0]  in_funct, in_op;
   logic        in_alusrc, in_memrd, in_memwr, in_regwr, stall, flush;
   logic        exmem_regwr, memwb_regwr;
   logic [3:0]  ALUctl;
   logic        ex_valid, ex_memrd, ex_memwr, ex_regwr, illegal;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit          valid, rst, alusrc, memrd, memwr, regwr, ill;
      int          rs, rt, rd, ctl;
      logic [31:0] rsv, rtv, imm;
   } ex_t;
   ex_t m;
   int fmap[int];
   int omap[int];

   id_ex_issue dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_rs(in_rs), .in_rt(in_rt), .in_rd_dst(in_rd_dst),
      .in_rs_val(in_rs_val), .in_rt_val(in_rt_val), .in_imm(in_imm),
      .in_aluop(in_aluop), .in_funct(in_funct), .in_op(in_op), .in_alusrc(in_alusrc),
      .in_memrd(in_memrd), .in_memwr(in_memwr), .in_regwr(in_regwr),
      .stall(stall), .flush(flush),
      .exmem_regwr(exmem_regwr), .memwb_regwr(memwb_regwr),
      .exmem_rd(exmem_rd), .memwb_rd(memwb_rd), .exmem_val(exmem_val), .memwb_val(memwb_val),
      .A(A), .B(B), .ALUctl(ALUctl), .st_data(st_data), .ex_rd(ex_rd),
      .ex_valid(ex_valid), .ex_memrd(ex_memrd), .ex_memwr(ex_memwr), .ex_regwr(ex_regwr),
      .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int model_ctl(input int aluop, input int funct, input int op);
      if (aluop == 0) return 2;
      if (aluop == 1) return 6;
      if (aluop == 2) return fmap.exists(funct) ? fmap[funct] : 15;
      return omap.exists(op) ? omap[op] : 15;
   endfunction

   function automatic logic [31:0] model_fwd(input int r, input logic [31:0] stored);
      if (r == 0) return stored;
      if (exmem_regwr && int'(exmem_rd) == r) return exmem_val;
      if (memwb_regwr && int'(memwb_rd) == r) return memwb_val;
      return stored;
   endfunction

   function automatic bit model_hz();
      return in_valid && m.valid && m.memrd && m.rd != 0 &&
             (m.rd == int'(in_rs) || m.rd == int'(in_rt));
   endfunction

   task automatic model_edge();
      bit hz;
      hz = model_hz();
      if (!rst_n) begin
         m = '{valid: 0, rst: 1, alusrc: 0, memrd: 0, memwr: 0, regwr: 0, ill: 0,
               rs: 0, rt: 0, rd: 0, ctl: 15, rsv: 0, rtv: 0, imm: 0};
      end else if (flush || (!stall && hz)) begin
         m.valid = 0; m.memrd = 0; m.memwr = 0; m.regwr = 0; m.rst = 0;
      end else if (!stall) begin
         m.valid  = in_valid;
         m.rst    = 0;
         m.rs     = in_rs;     m.rt  = in_rt;     m.rd = in_rd_dst;
         m.rsv    = in_rs_val; m.rtv = in_rt_val; m.imm = in_imm;
         m.alusrc = in_alusrc;
         m.memrd  = in_valid && in_memrd;
         m.memwr  = in_valid && in_memwr;
         m.regwr  = in_valid && in_regwr;
         m.ctl    = model_ctl(in_aluop, in_funct, in_op);
         m.ill    = in_valid && (m.ctl == 15);
      end
   endtask

   task automatic check_outputs();
      logic [31:0] eb;
      chk("ex_valid", ex_valid, m.valid);
      chk("ex_memrd", ex_memrd, m.memrd);
      chk("ex_memwr", ex_memwr, m.memwr);
      chk("ex_regwr", ex_regwr, m.regwr);
      if (m.valid || m.rst) begin
         eb = m.alusrc ? m.imm : model_fwd(m.rt, m.rtv);
         chk("ALUctl", ALUctl, m.ctl);
         chk("illegal", illegal, m.ill);
         chk("ex_rd", ex_rd, m.rd);
         chk("A", A, model_fwd(m.rs, m.rsv));
         chk("B", B, eb);
         chk("st_data", st_data, model_fwd(m.rt, m.rtv));
      end
   endtask

   // One clock: in_ready before the edge, model update at the edge, outputs at the next negedge.
   task automatic cycle();
      #1;
      chk("in_ready", in_ready, !stall && !model_hz());
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic idle();
      in_valid = 0; in_rs = 0; in_rt = 0; in_rd_dst = 0;
      in_rs_val = 0; in_rt_val = 0; in_imm = 0;
      in_aluop = 2'b00; in_funct = 6'h00; in_op = 6'h00; in_alusrc = 0;
      in_memrd = 0; in_memwr = 0; in_regwr = 0; stall = 0; flush = 0;
      exmem_regwr = 0; memwb_regwr = 0; exmem_rd = 0; memwb_rd = 0;
      exmem_val = 0; memwb_val = 0;
   endtask

   task automatic rtype(input int rs, input int rt, input logic [31:0] rsv,
                        input logic [31:0] rtv, input logic [5:0] fn);
      idle();
      in_valid = 1; in_rs = 5'(rs); in_rt = 5'(rt); in_rd_dst = 5'd9;
      in_rs_val = rsv; in_rt_val = rtv; in_aluop = 2'b10; in_funct = fn; in_regwr = 1;
   endtask

   initial begin
      bit prev_valid;
      int fns[6];
      int ops[4];
      fmap[32'h20] = 2; fmap[32'h22] = 6; fmap[32'h24] = 0;
      fmap[32'h25] = 1; fmap[32'h27] = 12; fmap[32'h2A] = 7;
      omap[32'h08] = 2; omap[32'h0C] = 0; omap[32'h0D] = 1; omap[32'h0A] = 7;
      fns = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h27, 32'h2A};
      ops = '{32'h08, 32'h0C, 32'h0D, 32'h0A};

      idle();
      rst_n = 0;
      cycle();
      cycle();
      chk("rst_ctl", ALUctl, 32'd15);
      chk("rst_A", A, 32'd0);
      rst_n = 1;

      // R-type add
      rtype(1, 2, 32'd5, 32'd7, 6'h20);
      cycle();
      chk("t1_ctl", ALUctl, 32'd2);
      chk("t1_A", A, 32'd5);
      chk("t1_B", B, 32'd7);
      chk("t1_valid", ex_valid, 1'b1);

      // NOR, illegal funct, ORI with immediate
      rtype(1, 2, 32'd1, 32'd2, 6'h27);
      cycle();
      chk("t2_nor", ALUctl, 32'd12);
      rtype(1, 2, 32'd1, 32'd2, 6'h3F);
      cycle();
      chk("t2_ill_ctl", ALUctl, 32'd15);
      chk("t2_ill", illegal, 1'b1);
      idle();
      in_valid = 1; in_aluop = 2'b11; in_op = 6'h0D; in_alusrc = 1; in_imm = 32'hFF;
      in_rs = 5'd4; in_rd_dst = 5'd4; in_regwr = 1;
      cycle();
      chk("t2_ori_ctl", ALUctl, 32'd1);
      chk("t2_ori_B", B, 32'hFF);

      // load-use hazard: lw r8 then consumer of r8
      idle();
      in_valid = 1; in_rs = 5'd1; in_rd_dst = 5'd8; in_memrd = 1; in_regwr = 1;
      cycle();
      rtype(8, 2, 32'd3, 32'd4, 6'h20);
      #1;
      chk("t3_ready", in_ready, 1'b0);
      cycle();
      chk("t3_bubble", ex_valid, 1'b0);
      chk("t3_regwr", ex_regwr, 1'b0);
      cycle();
      chk("t3_accept", ex_valid, 1'b1);

      // forwarding priority, then rs=0
      rtype(3, 0, 32'h11, 32'h22, 6'h20);
      cycle();
      exmem_regwr = 1; exmem_rd = 5'd3; exmem_val = 32'hAA;
      memwb_regwr = 1; memwb_rd = 5'd3; memwb_val = 32'hBB;
      #1;
      chk("t4_fwd", A, 32'hAA);
      rtype(0, 0, 32'h33, 32'h44, 6'h20);
      cycle();
      exmem_regwr = 1; exmem_rd = 5'd0; exmem_val = 32'hAA;
      memwb_regwr = 1; memwb_rd = 5'd0; memwb_val = 32'hBB;
      #1;
      chk("t4_zero", A, 32'h33);

      // stall freezes the stage, flush overrides stall
      rtype(5, 6, 32'h55, 32'h66, 6'h22);
      cycle();
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         in_valid = !in_valid;
         in_rs_val = $urandom;
         cycle();
         chk("t5_hold_A", A, 32'h55);
      end
      flush = 1;
      cycle();
      chk("t5_flush", ex_valid, 1'b0);

      // reset mid-stream
      rtype(5, 6, 32'h77, 32'h88, 6'h20);
      cycle();
      rst_n = 0;
      cycle();
      chk("t6_valid", ex_valid, 1'b0);
      chk("t6_ctl", ALUctl, 32'd15);
      chk("t6_B", B, 32'd0);
      rst_n = 1;
      rtype(5, 6, 32'h99, 32'h88, 6'h24);
      cycle();
      chk("t6_latency", A, 32'h99);

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         prev_valid = in_valid;
         in_valid    = ($urandom_range(0, 3) != 0);
         in_rs       = 5'($urandom_range(0, 7));
         in_rt       = 5'($urandom_range(0, 7));
         in_rd_dst   = 5'($urandom_range(0, 7));
         in_rs_val   = $urandom;
         in_rt_val   = $urandom;
         in_imm      = $urandom;
         in_aluop    = 2'($urandom_range(0, 3));
         in_funct    = ($urandom_range(0, 4) == 0) ? 6'($urandom) : 6'(fns[$urandom_range(0, 5)]);
         in_op       = ($urandom_range(0, 4) == 0) ? 6'($urandom) : 6'(ops[$urandom_range(0, 3)]);
         in_alusrc   = 1'($urandom);
         in_memrd    = ($urandom_range(0, 2) == 0);
         in_memwr    = 1'($urandom);
         in_regwr    = 1'($urandom);
         stall       = ($urandom_range(0, 9) == 0);
         flush       = ($urandom_range(0, 11) == 0);
         rst_n       = ($urandom_range(0, 60) != 0);
         exmem_regwr = 1'($urandom);
         memwb_regwr = 1'($urandom);
         exmem_rd    = 5'($urandom_range(0, 7));
         memwb_rd    = 5'($urandom_range(0, 7));
         exmem_val   = $urandom;
         memwb_val   = $urandom;
         if (prev_valid && !in_ready && !stall) in_valid = 1;
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
